// File: rtl/hazard_scoreboard.sv
// Hazard and forwarding unit for the 5-stage F/R/X/M/W core: stage enables, forwarding selects,
// load-use bubbles, memory-wait freezes and deferred flushes. Optional counters: HAZARD_PERF_EN.
module hazard_scoreboard #(
  parameter int REG_AW = 3,
  parameter int NSRC   = 2,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NSRC-1:0]        r_src_valid,
  input  logic [NSRC*REG_AW-1:0] r_src_addr,
  input  logic                   r_alu_wr,
  input  logic [REG_AW-1:0]      r_alu_dst,
  input  logic                   r_mem_wr,
  input  logic [REG_AW-1:0]      r_mem_dst,
  input  logic                   mem_ready,
  input  logic                   flush,
  output logic                   en_f,
  output logic                   en_r,
  output logic                   en_x,
  output logic                   en_m,
  output logic                   en_w,
  output logic                   bubble_x,
  output logic [NSRC*5-1:0]      fwd,
  output logic                   load_use_stall
`ifdef HAZARD_PERF_EN
  ,
  output logic [CNT_W-1:0]       perf_lu_stalls,
  output logic [CNT_W-1:0]       perf_mem_waits,
  output logic [CNT_W-1:0]       perf_flushes
`endif
);

  typedef struct packed {
    logic              alu_wr;
    logic [REG_AW-1:0] alu_dst;
    logic              mem_wr;
    logic [REG_AW-1:0] mem_dst;
  } stage_t;

  stage_t sx, sm, sw, r_info;
  logic   pend_flush;
  logic   flush_eff;
  logic   lu_cond;

  assign r_info    = '{alu_wr: r_alu_wr, alu_dst: r_alu_dst, mem_wr: r_mem_wr, mem_dst: r_mem_dst};
  assign flush_eff = flush | pend_flush;

  always_comb begin
    logic [REG_AW-1:0] a;
    logic [4:0]        sel;
    lu_cond = 1'b0;
    fwd     = '0;
    for (int unsigned s = 0; s < NSRC; s++) begin
      a   = r_src_addr[s*REG_AW +: REG_AW];
      sel = '0;
      if (r_src_valid[s]) begin
        if (sx.mem_wr && a == sx.mem_dst) lu_cond = 1'b1;
        // loads in X are never forwarded; the stall covers them
        if (sx.alu_wr && a == sx.alu_dst)      sel = 5'b10000;
        else if (sm.mem_wr && a == sm.mem_dst) sel = 5'b00100;
        else if (sm.alu_wr && a == sm.alu_dst) sel = 5'b01000;
        else if (sw.mem_wr && a == sw.mem_dst) sel = 5'b00001;
        else if (sw.alu_wr && a == sw.alu_dst) sel = 5'b00010;
      end
      fwd[s*5 +: 5] = sel;
    end
  end

  always_comb begin
    load_use_stall = lu_cond & mem_ready;
    en_w           = 1'b1;
    en_x           = mem_ready;
    en_m           = mem_ready;
    en_f           = mem_ready & ~load_use_stall & ~flush_eff;
    en_r           = en_f;
    bubble_x       = mem_ready & (load_use_stall | flush_eff);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sx         <= '0;
      sm         <= '0;
      sw         <= '0;
      pend_flush <= 1'b0;
    end else if (!mem_ready) begin
      sw         <= '0;
      pend_flush <= pend_flush | flush;
    end else begin
      sw         <= sm;
      sm         <= sx;
      sx         <= bubble_x ? '0 : r_info;
      pend_flush <= 1'b0;
    end
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_lu_stalls <= '0;
      perf_mem_waits <= '0;
      perf_flushes   <= '0;
    end else begin
      if (load_use_stall && perf_lu_stalls != '1) perf_lu_stalls <= perf_lu_stalls + 1'b1;
      if (!mem_ready && perf_mem_waits != '1)     perf_mem_waits <= perf_mem_waits + 1'b1;
      if (mem_ready && flush_eff && perf_flushes != '1) perf_flushes <= perf_flushes + 1'b1;
    end
  end
`else
  logic [CNT_W-1:0] unused_perf;
  assign unused_perf = '0;
`endif

endmodule
